// File: rtl/rnd_range_reducer.sv
// Captures a random sample, reduces it modulo a run-time range by repeated
// subtraction, and queues results in a small FIFO behind a valid/ready port.
module rnd_range_reducer #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] rnd_in,
    input  logic         rnd_valid,
    input  logic [W-1:0] range_n,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [7:0]   drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        PUSH
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  mod_q, mod_d;
    logic [7:0]    drop_q, drop_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic full;
    logic pop;
    logic push;

    assign full = (count_q == CNT_FULL);
    assign pop  = (count_q != '0) && out_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mod_d   = mod_q;
        drop_d  = drop_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rnd_valid) begin
                    rem_d   = rnd_in;
                    mod_d   = range_n;
                    // A zero range stands for 2^W: nothing to reduce.
                    state_d = (range_n == '0) ? PUSH : REDUCE;
                end
            end
            REDUCE: begin
                if (rem_q >= mod_q) begin
                    rem_d = rem_q - mod_q;
                end else begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                state_d = IDLE;
                if (!full || pop) begin
                    push = 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rem_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            mod_q    <= '0;
            drop_q   <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mod_q    <= mod_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign busy       = (state_q != IDLE);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_rnd_range_reducer.sv
// Directed-vector bench for rnd_range_reducer.
// Cycle n is observed 1 time unit after the n-th rising edge after a strobe.
module tb_rnd_range_reducer;

    logic       clock;
    logic       reset;
    logic [9:0] rnd_in;
    logic       rnd_valid;
    logic [9:0] range_n;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] drop_count;

    int checks;
    int failures;

    rnd_range_reducer #(
        .DEPTH(4),
        .W    (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .range_n   (range_n),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        rnd_in    = '0;
        range_n   = '0;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        rnd_in    = '0;
        range_n   = '0;
        steps(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%0b exp=0", busy);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (out_data !== 10'd0) begin
            failures++;
            $display("FAIL reset_out_data got=%0d exp=0", out_data);
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop got=%0d exp=0", drop_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        rnd_in    = 10'd700;
        range_n   = 10'd6;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        range_n   = 10'd7;
        rnd_in    = 10'd3;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_c1 busy=%0b valid=%0b exp busy=1 valid=0",
                     busy, out_valid);
        end
        steps(117);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_c118 busy=%0b valid=%0b exp busy=1 valid=0",
                     busy, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd4) begin
            failures++;
            $display("FAIL basic_c119 valid=%0b data=%0d exp valid=1 data=4",
                     out_valid, out_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_low got=%0b exp=0", busy);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pop got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_passthru();
        do_reset();
        rnd_in    = 10'h3FF;
        range_n   = 10'd0;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pass_c1 busy=%0b valid=%0b exp busy=1 valid=0",
                     busy, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd1023 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pass_c2 valid=%0b data=%0d busy=%0b exp 1/1023/0",
                     out_valid, out_data, busy);
        end
    endtask

    task automatic test_fifo_drop();
        int vals [5];
        int exp_v [4];
        vals  = '{10, 20, 30, 40, 50};
        exp_v = '{10, 20, 30, 40};
        do_reset();
        range_n   = 10'd1000;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rnd_in    = 10'(vals[k]);
            rnd_valid = 1'b1;
            step();
            rnd_valid = 1'b0;
            steps(3);
        end
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("FAIL fifo_drop got=%0d exp=1", drop_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'(exp_v[i])) begin
                failures++;
                $display("FAIL fifo_pop%0d valid=%0b data=%0d exp valid=1 data=%0d",
                         i, out_valid, out_data, exp_v[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_empty got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_ignore_busy();
        int extra;
        do_reset();
        rnd_in    = 10'd900;
        range_n   = 10'd3;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        steps(49);
        rnd_in    = 10'd5;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        steps(251);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ign_c302 valid=%0b busy=%0b exp valid=0 busy=1",
                     out_valid, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_c303 valid=%0b data=%0d busy=%0b exp 1/0/0",
                     out_valid, out_data, busy);
        end
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL ign_drop got=%0d exp=0", drop_count);
        end
        out_ready = 1'b1;
        step();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1 || busy === 1'b1) extra++;
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL ign_extra got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        rnd_in    = 10'd700;
        range_n   = 10'd6;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        steps(39);
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset busy=%0b valid=%0b drop=%0d exp 0/0/0",
                     busy, out_valid, drop_count);
        end
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 150; i++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_reset_out got=%0d exp=0", seen);
        end
    endtask

    task automatic test_full_push_pop();
        int fill [4];
        int exp_v [4];
        fill  = '{11, 22, 33, 44};
        exp_v = '{22, 33, 44, 777};
        do_reset();
        range_n   = 10'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rnd_in    = 10'(fill[k]);
            rnd_valid = 1'b1;
            step();
            rnd_valid = 1'b0;
            step();
        end
        rnd_in    = 10'd777;
        rnd_valid = 1'b1;
        step();
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (drop_count !== 8'd0 || out_valid !== 1'b1 || out_data !== 10'd22) begin
            failures++;
            $display("FAIL fpp_c2 drop=%0d valid=%0b data=%0d exp 0/1/22",
                     drop_count, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'(exp_v[i])) begin
                failures++;
                $display("FAIL fpp_pop%0d valid=%0b data=%0d exp valid=1 data=%0d",
                         i, out_valid, out_data, exp_v[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fpp_empty got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        range_n   = 10'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 304; i++) begin
            rnd_in    = 10'(100 + i);
            rnd_valid = 1'b1;
            step();
            rnd_valid = 1'b0;
            step();
            if (i == 13) begin
                checks++;
                if (drop_count !== 8'd10) begin
                    failures++;
                    $display("FAIL sat_mid got=%0d exp=10", drop_count);
                end
            end
        end
        checks++;
        if (drop_count !== 8'd255) begin
            failures++;
            $display("FAIL sat_end got=%0d exp=255", drop_count);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd100) begin
            failures++;
            $display("FAIL sat_head valid=%0b data=%0d exp valid=1 data=100",
                     out_valid, out_data);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        rnd_in    = '0;
        range_n   = '0;
        #1;
        test_reset();
        test_basic();
        test_passthru();
        test_fifo_drop();
        test_ignore_busy();
        test_reset_mid();
        test_full_push_pop();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rnd_range_reducer.md
# rnd_range_reducer

Downstream consumer of the 10-bit LFSR random number generator. It captures a fresh random sample on a strobe and reduces it modulo a run-time range with a sequential subtract loop. Results are buffered in a small FIFO and delivered over a valid/ready interface, which hands uniform-ish values in `[0, range_n-1]` to game/test logic further down the chain.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `W`, 10: sample/result width; matches the generator output.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: synchronous, active-high.
- `rnd_in`, in, W: random sample from the generator.
- `rnd_valid`, in, 1: one-cycle strobe, high when the generator publishes a new sample.
- `range_n`, in, W: modulus; sampled only at capture; 0 means 2^W (pass-through).
- `out_data`, out, W: FIFO head value.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: consumer accepts the head this cycle.
- `busy`, out, 1: FSM not in IDLE.
- `drop_count`, out, 8: count of results lost to a full FIFO; saturates at 255.

## Operation
- FSM states: IDLE, REDUCE, PUSH.
- **IDLE**: on `rnd_valid`=1, latch `rem`<=`rnd_in` and `mod`<=`range_n`.
  - If `range_n`==0, go to PUSH.
  - Otherwise go to REDUCE.
- **REDUCE**: each cycle, if `rem` >= `mod` then `rem`<=`rem`-`mod` and stay in REDUCE; else go to PUSH.
  - Compare and subtract are unsigned W-bit; `rem` never underflows.
- **PUSH**: write `rem` into the FIFO if not full, or if a pop occurs in the same cycle. Otherwise increment `drop_count` (saturating). Go to IDLE.
- `rnd_valid` while `busy`=1 is ignored: not queued, not counted.
- `range_n` changes after capture have no effect on the in-flight sample.
- FIFO behaviour:
  - Pop when `out_valid` && `out_ready`.
  - Simultaneous push and pop when full: both occur; occupancy is unchanged.
  - Simultaneous push and pop when empty: the push is written, and `out_valid` rises the next cycle (no bypass).
  - Pointers wrap modulo `DEPTH`; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- `out_data` is the registered/array head. It is held stable while `out_valid`=1 and `out_ready`=0.
- Reset values: state IDLE, FIFO empty, `out_valid`=0, `out_data`=0 (storage cleared), `busy`=0, `drop_count`=0, `rem`=`mod`=0.
- Reset mid-REDUCE or mid-PUSH aborts the in-flight sample: no FIFO write and no drop count.

## Timing
- Define q = floor(`rnd_in`/`range_n`); q=0 when `range_n`==0.
- Latency: with `rnd_valid` high in cycle 0, `busy`=1 from cycle 1.
  - REDUCE occupies cycles 1..q+1.
  - PUSH occurs in cycle q+2.
  - `out_valid` is 1 in cycle q+3 when the FIFO was empty.
- `range_n`==0 path: PUSH in cycle 1, `out_valid` in cycle 2.
- Worst case: `range_n`=1, `rnd_in`=1023, giving PUSH at cycle 1025.
- `busy` falls the cycle after PUSH; a new capture is possible that same cycle.
- Throughput: one result per q+3 cycles. FIFO pop rate is 1 per cycle.
- All outputs are registered or derived from registers only; no combinational path from `rnd_in`/`rnd_valid` to outputs.

## Test plan
- Reset, then `rnd_in`=700, `range_n`=6, one strobe in cycle 0, `out_ready`=0 -> q=116, `out_valid` rises in cycle 119 with `out_data`=4; `busy` low from cycle 119.
- `range_n`=0, `rnd_in`=10'h3FF -> `out_data`=1023, `out_valid` in cycle 2; no REDUCE cycles.
- `out_ready`=0, `range_n`=1000, five strobes spaced 4 cycles apart with values 10/20/30/40/50 -> FIFO holds 10,20,30,40 and `drop_count`=1. Then `out_ready`=1 pops 10,20,30,40 on consecutive cycles, and `out_valid`=0 afterwards.
- Strobe 900 with `range_n`=3 (q=300), second strobe value 5 at cycle 50 -> exactly one output, value 0; the second strobe is ignored and `drop_count` stays 0.
- Reset asserted at cycle 40 of the 700/6 case -> next cycle `busy`=0, `out_valid`=0, `drop_count`=0; no output ever appears.
- FIFO full with `out_ready`=0, more than 300 further strobes -> `drop_count` saturates at 255. With the FIFO full and `out_ready`=1 in the PUSH cycle, the new value is accepted and `drop_count` is unchanged.
